// File: rtl/character_anim_sequencer.sv
// rtl/character_anim_sequencer.sv - physics state to sprite animation sequencer
// Optional SLEEP animation after a long idle stretch is enabled by defining SLEEP_ANIM_EN.
module character_anim_sequencer #(
  parameter int SIGNED_PHY_WIDTH = 17,
  parameter int REFRESH_RATE     = 64,
  parameter int BREATHE_TICKS    = 32,
  parameter int HARD_LAND_VEL    = 2,
  parameter int LAND_TICKS       = 64,
  parameter int BUMP_TICKS       = 8,
  parameter int WALK_FRAMES      = 4,
  parameter int WALK_DIV         = 8,
  parameter int CHARGE_FRAMES    = 3,
  parameter int CHARGE_DIV       = 16,
  parameter int FRAME_W          = 3
) (
  input  logic                               sys_clk,
  input  logic                               sys_rst,
  input  logic                               character_clk,
  input  logic [2:0]                         char_state,
  input  logic signed [SIGNED_PHY_WIDTH-1:0] vel_y,
  output logic [3:0]                         anim_id,
  output logic [FRAME_W-1:0]                 frame_idx,
  output logic                               facing_left,
  output logic                               anim_done
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_LEFT, ST_RIGHT, ST_CHARGE, ST_JUMP, ST_COLLISION, ST_FALL, ST_HOLD
  } char_state_e;

  typedef enum logic [3:0] {
    A_IDLE_A, A_IDLE_B, A_WALK, A_CHARGE, A_JUMP_UP, A_JUMP_DOWN,
    A_BUMP, A_LAND_SOFT, A_LAND_HARD, A_SLEEP
  } anim_e;

  localparam int VW     = SIGNED_PHY_WIDTH;
  localparam int HOLD_W = $clog2(((LAND_TICKS > BUMP_TICKS) ? LAND_TICKS : BUMP_TICKS) + 1);
  localparam int IDLE_W = $clog2(REFRESH_RATE + 1);
  localparam int DIV_W  = $clog2(((WALK_DIV > CHARGE_DIV) ? WALK_DIV : CHARGE_DIV) + 1);

  localparam logic [HOLD_W-1:0]   LAND_LAST   = HOLD_W'(LAND_TICKS - 1);
  localparam logic [HOLD_W-1:0]   BUMP_LAST   = HOLD_W'(BUMP_TICKS - 1);
  localparam logic [IDLE_W-1:0]   IDLE_LAST   = IDLE_W'(REFRESH_RATE - 1);
  localparam logic [IDLE_W-1:0]   BREATHE_LEN = IDLE_W'(BREATHE_TICKS);
  localparam logic [DIV_W-1:0]    WALK_LDIV   = DIV_W'(WALK_DIV - 1);
  localparam logic [DIV_W-1:0]    CHARGE_LDIV = DIV_W'(CHARGE_DIV - 1);
  localparam logic [FRAME_W-1:0]  WALK_LFR    = FRAME_W'(WALK_FRAMES - 1);
  localparam logic [FRAME_W-1:0]  CHARGE_LFR  = FRAME_W'(CHARGE_FRAMES - 1);
  localparam logic signed [VW-1:0] HARD_THR   = VW'(-HARD_LAND_VEL);
`ifdef SLEEP_ANIM_EN
  localparam logic [9:0]          SLEEP_AT    = 10'(8 * REFRESH_RATE);
`endif

  logic                   tick_q;
  char_state_e            state_q;
  logic signed [VW-1:0]   vel_q;
  anim_e                  anim_q, anim_d;
  logic [FRAME_W-1:0]     frame_q, frame_d;
  logic                   facing_q, facing_d;
  logic                   done_q, done_d;
  logic [HOLD_W-1:0]      hold_q, hold_d;
  logic [IDLE_W-1:0]      idle_q, idle_d;
  logic [DIV_W-1:0]       div_q, div_d;
  logic signed [VW-1:0]   peak_q, peak_d;
`ifdef SLEEP_ANIM_EN
  logic [9:0]             sleep_q, sleep_d;
`endif

  logic                   sel;
  logic                   vel_neg, vel_pos;
  logic signed [VW-1:0]   land_m;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      tick_q   <= 1'b0;
      state_q  <= ST_IDLE;
      vel_q    <= '0;
      anim_q   <= A_IDLE_A;
      frame_q  <= '0;
      facing_q <= 1'b0;
      done_q   <= 1'b0;
      hold_q   <= '0;
      idle_q   <= '0;
      div_q    <= '0;
      peak_q   <= '0;
`ifdef SLEEP_ANIM_EN
      sleep_q  <= '0;
`endif
    end else begin
      tick_q   <= character_clk;
      state_q  <= char_state_e'(char_state);
      vel_q    <= vel_y;
      anim_q   <= anim_d;
      frame_q  <= frame_d;
      facing_q <= facing_d;
      done_q   <= done_d;
      hold_q   <= hold_d;
      idle_q   <= idle_d;
      div_q    <= div_d;
      peak_q   <= peak_d;
`ifdef SLEEP_ANIM_EN
      sleep_q  <= sleep_d;
`endif
    end
  end

  always_comb begin
    anim_d   = anim_q;
    frame_d  = frame_q;
    facing_d = facing_q;
    done_d   = 1'b0;
    hold_d   = hold_q;
    idle_d   = idle_q;
    div_d    = div_q;
    peak_d   = peak_q;
`ifdef SLEEP_ANIM_EN
    sleep_d  = sleep_q;
`endif
    sel      = 1'b0;
    vel_neg  = vel_q[VW-1];
    vel_pos  = (vel_q != '0) && !vel_q[VW-1];
    land_m   = (peak_q < vel_q) ? peak_q : vel_q;

    if (tick_q) begin
      if (state_q == ST_LEFT) facing_d = 1'b1;
      else if (state_q == ST_RIGHT) facing_d = 1'b0;

      // Held animations: expiry wins over an override arriving on the same tick.
      case (anim_q)
        A_LAND_HARD: begin
          if (hold_q == LAND_LAST) begin done_d = 1'b1; sel = 1'b1; end
          else hold_d = hold_q + 1'b1;
        end
        A_LAND_SOFT: begin
          if (hold_q == LAND_LAST) begin done_d = 1'b1; sel = 1'b1; end
          else if (state_q inside {ST_LEFT, ST_RIGHT, ST_CHARGE, ST_JUMP}) sel = 1'b1;
          else hold_d = hold_q + 1'b1;
        end
        A_BUMP: begin
          if (hold_q == BUMP_LAST) begin done_d = 1'b1; sel = 1'b1; end
          else if (state_q == ST_FALL) sel = 1'b1;
          else hold_d = hold_q + 1'b1;
        end
        default: sel = 1'b1;
      endcase

      if (sel) begin
        hold_d = '0;
        case (state_q)
          ST_LEFT, ST_RIGHT: begin
            anim_d = A_WALK;
            if (anim_q != A_WALK) begin
              frame_d = '0;
              div_d   = '0;
            end else if (div_q == WALK_LDIV) begin
              div_d   = '0;
              frame_d = (frame_q == WALK_LFR) ? '0 : frame_q + 1'b1;
            end else begin
              div_d   = div_q + 1'b1;
            end
          end
          ST_CHARGE: begin
            anim_d = A_CHARGE;
            if (anim_q != A_CHARGE) begin
              frame_d = '0;
              div_d   = '0;
            end else if (div_q == CHARGE_LDIV) begin
              div_d   = '0;
              frame_d = (frame_q == CHARGE_LFR) ? frame_q : frame_q + 1'b1;
            end else begin
              div_d   = div_q + 1'b1;
            end
          end
          ST_JUMP: begin
            if (vel_pos) anim_d = A_JUMP_UP;
            else if (vel_neg) anim_d = A_JUMP_DOWN;
          end
          ST_COLLISION: anim_d = A_BUMP;
          ST_FALL: begin
            if (anim_q != A_LAND_SOFT && anim_q != A_LAND_HARD) begin
              if (land_m < HARD_THR) anim_d = A_LAND_HARD;
              else anim_d = A_LAND_SOFT;
            end
          end
          default: begin
            if (vel_pos) anim_d = A_JUMP_UP;
            else if (vel_neg) anim_d = A_JUMP_DOWN;
`ifdef SLEEP_ANIM_EN
            else if (anim_q == A_SLEEP || sleep_q == SLEEP_AT) anim_d = A_SLEEP;
`endif
            else if (idle_q < BREATHE_LEN) anim_d = A_IDLE_A;
            else anim_d = A_IDLE_B;
          end
        endcase
      end

      if (anim_d != A_WALK && anim_d != A_CHARGE) frame_d = '0;

      if (anim_d == A_IDLE_A || anim_d == A_IDLE_B) idle_d = (idle_q == IDLE_LAST) ? '0 : idle_q + 1'b1;
`ifdef SLEEP_ANIM_EN
      else if (anim_d == A_SLEEP) idle_d = idle_q;
`endif
      else idle_d = '0;

`ifdef SLEEP_ANIM_EN
      if (anim_d == A_IDLE_A || anim_d == A_IDLE_B) sleep_d = sleep_q + 1'b1;
      else if (anim_d != A_SLEEP) sleep_d = '0;
`endif

      if (anim_d == A_JUMP_UP || anim_d == A_JUMP_DOWN) peak_d = (vel_q < peak_q) ? vel_q : peak_q;
      else if (anim_d inside {A_LAND_SOFT, A_LAND_HARD, A_IDLE_A, A_WALK}) peak_d = '0;
    end
  end

  assign anim_id     = anim_q;
  assign frame_idx   = frame_q;
  assign facing_left = facing_q;
  assign anim_done   = done_q;

endmodule

// File: tb/tb_character_anim_sequencer.sv
// tb/tb_character_anim_sequencer.sv - randomized bench against a tick-level animation model
module tb_character_anim_sequencer;
  localparam int W = 17;
  localparam int REFRESH = 64, BREATHE = 32, HARD = 2, LAND = 64, BUMP = 8;
  localparam int WFR = 4, WDIV = 8, CFR = 3, CDIV = 16;

  logic          sys_clk = 1'b0;
  logic          sys_rst;
  logic          character_clk;
  logic [2:0]    char_state;
  logic signed [W-1:0] vel_y;
  logic [3:0]    anim_id;
  logic [2:0]    frame_idx;
  logic          facing_left;
  logic          anim_done;

  int checks = 0, failures = 0, done_seen = 0;

  // Model: animation codes, ticks spent in a held animation, ticks into walk/charge, idle phase.
  int m_anim, m_frame, m_face, m_done, m_age, m_walk_t, m_charge_t, m_idle, m_peak;

  always #5 sys_clk = ~sys_clk;

  character_anim_sequencer #(
    .SIGNED_PHY_WIDTH(W), .REFRESH_RATE(REFRESH), .BREATHE_TICKS(BREATHE),
    .HARD_LAND_VEL(HARD), .LAND_TICKS(LAND), .BUMP_TICKS(BUMP),
    .WALK_FRAMES(WFR), .WALK_DIV(WDIV), .CHARGE_FRAMES(CFR), .CHARGE_DIV(CDIV), .FRAME_W(3)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .character_clk(character_clk),
    .char_state(char_state), .vel_y(vel_y), .anim_id(anim_id),
    .frame_idx(frame_idx), .facing_left(facing_left), .anim_done(anim_done)
  );

  task automatic check_eq(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_anim = 0; m_frame = 0; m_face = 0; m_done = 0; m_age = 0;
    m_walk_t = 0; m_charge_t = 0; m_idle = 0; m_peak = 0;
  endtask

  task automatic model_step(input int st, input int v);
    int prev, len, mv;
    bit again;
    m_done = 0;
    prev = m_anim;
    if (st == 1) m_face = 1;
    else if (st == 2) m_face = 0;
    again = !(prev == 6 || prev == 7 || prev == 8);
    if (!again) begin
      len = (prev == 6) ? BUMP : LAND;
      if (m_age + 1 == len) begin m_done = 1; again = 1; end
      else if (prev == 7 && st >= 1 && st <= 4) again = 1;
      else if (prev == 6 && st == 6) again = 1;
      else m_age++;
    end
    if (again) begin
      m_age = 0;
      case (st)
        1, 2: if (prev == 2) m_walk_t++; else begin m_anim = 2; m_walk_t = 0; end
        3: if (prev == 3) m_charge_t++; else begin m_anim = 3; m_charge_t = 0; end
        4: if (v > 0) m_anim = 4; else if (v < 0) m_anim = 5;
        5: m_anim = 6;
        6: if (prev != 7 && prev != 8) begin
             mv = (m_peak < v) ? m_peak : v;
             m_anim = (mv < -HARD) ? 8 : 7;
           end
        default: if (v > 0) m_anim = 4; else if (v < 0) m_anim = 5;
                 else m_anim = (m_idle < BREATHE) ? 0 : 1;
      endcase
    end
    m_idle = (m_anim <= 1) ? (m_idle + 1) % REFRESH : 0;
    if (m_anim == 4 || m_anim == 5) m_peak = (v < m_peak) ? v : m_peak;
    else if (m_anim == 0 || m_anim == 2 || m_anim == 7 || m_anim == 8) m_peak = 0;
    if (m_anim == 2) m_frame = (m_walk_t / WDIV) % WFR;
    else if (m_anim == 3) m_frame = (m_charge_t / CDIV < CFR - 1) ? m_charge_t / CDIV : CFR - 1;
    else m_frame = 0;
  endtask

  task automatic do_tick(input int st, input int v);
    char_state = 3'(st); vel_y = W'(v); character_clk = 1'b1;
    @(negedge sys_clk);
    character_clk = 1'b0;
    char_state = 3'($urandom_range(0, 7));
    vel_y = W'(int'($urandom_range(0, 200)) - 100);
    @(negedge sys_clk);
    model_step(st, v);
    check_eq("anim_id", anim_id, m_anim);
    check_eq("frame_idx", frame_idx, m_frame);
    check_eq("facing_left", facing_left, m_face);
    check_eq("anim_done", anim_done, m_done);
    if (anim_done) done_seen++;
    @(negedge sys_clk);
    check_eq("done_width", anim_done, 0);
  endtask

  initial begin
    int st, len, v, base;
    sys_rst = 1'b1; character_clk = 1'b0; char_state = 3'd0; vel_y = '0;
    m_reset();
    repeat (3) @(negedge sys_clk);
    check_eq("rst_anim", anim_id, 0);
    check_eq("rst_frame", frame_idx, 0);
    check_eq("rst_facing", facing_left, 0);
    check_eq("rst_done", anim_done, 0);
    sys_rst = 1'b0;
    @(negedge sys_clk);

    for (int i = 0; i < 65; i++) begin
      do_tick(0, 0);
      if (i == 31) check_eq("idle_a_end", anim_id, 0);
      if (i == 32) check_eq("idle_b_start", anim_id, 1);
      if (i == 64) check_eq("idle_wrap", anim_id, 0);
    end

    for (int i = 0; i < 40; i++) begin
      do_tick(1, 0);
      if (i == 24) check_eq("walk_f3", frame_idx, 3);
      if (i == 32) check_eq("walk_wrap", frame_idx, 0);
    end
    for (int i = 0; i < 4; i++) do_tick(2, 0);
    check_eq("walk_right_facing", facing_left, 0);

    for (int i = 0; i < 3; i++) do_tick(4, 5);
    for (int i = 1; i <= 6; i++) do_tick(4, -i);
    done_seen = 0;
    do_tick(6, -1);
    check_eq("land_hard", anim_id, 8);
    for (int i = 0; i < 10; i++) do_tick(1, 0);
    check_eq("land_hard_ignores_left", anim_id, 8);
    for (int i = 0; i < 60; i++) do_tick(0, 0);
    check_eq("land_hard_one_done", done_seen, 1);

    for (int i = 0; i < 3; i++) do_tick(4, 3 - i - 2);
    do_tick(4, -2);
    done_seen = 0;
    do_tick(6, 0);
    check_eq("land_soft", anim_id, 7);
    for (int i = 0; i < 9; i++) do_tick(6, 0);
    for (int i = 0; i < 40; i++) do_tick(3, 0);
    check_eq("charge_sat", frame_idx, 2);
    check_eq("soft_override_no_done", done_seen, 0);

    done_seen = 0;
    do_tick(5, 0);
    check_eq("bump", anim_id, 6);
    for (int i = 0; i < 10; i++) do_tick(0, 0);
    check_eq("bump_one_done", done_seen, 1);
    check_eq("bump_to_idle", anim_id, 0);

    do_tick(4, -9);
    do_tick(6, -1);
    for (int i = 0; i < 5; i++) do_tick(1, 0);
    char_state = 3'd0; vel_y = '0; character_clk = 1'b1;
    @(negedge sys_clk);
    character_clk = 1'b0; sys_rst = 1'b1;
    @(negedge sys_clk);
    check_eq("midrst_anim", anim_id, 0);
    check_eq("midrst_frame", frame_idx, 0);
    check_eq("midrst_facing", facing_left, 0);
    check_eq("midrst_done", anim_done, 0);
    sys_rst = 1'b0;
    m_reset();
    @(negedge sys_clk);

    for (int seg = 0; seg < 150; seg++) begin
      st = $urandom_range(0, 7);
      len = $urandom_range(1, 24);
      if ($urandom_range(0, 4) == 0) len += 60;
      base = $urandom_range(0, 8);
      for (int k = 0; k < len; k++) begin
        if (st == 4) v = base - k;
        else if ($urandom_range(0, 9) < 5) v = 0;
        else if ($urandom_range(0, 9) == 0) v = ($urandom_range(0, 1) != 0) ? int'($urandom_range(1, 65535)) : -int'($urandom_range(1, 65536));
        else v = int'($urandom_range(0, 12)) - 6;
        do_tick(st, v);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
